hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Owns the architectural HI/LO register pair that the writeback stage reads for MFHI/MFLO.
- Sequences a 32-iteration restoring divider for DIV/DIVU and commits the remainder to HI and the quotient to LO.
- Arbitrates HI/LO writes between divide completion and MTHI/MTLO.
- Gives the EX stage a valid/ready request handshake and a one-cycle done pulse, which EX uses as its ready_go.

Parameters:
- DATA_W, 32: operand and HI/LO width; only 32 is supported.
- HILO_RST_VAL, 32'h0: value loaded into HI and LO on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- div_valid  in  1  EX presents a divide request.
- div_signed  in  1  1 = DIV, 0 = DIVU; sampled on accept.
- div_dividend  in  32  rs value; sampled on accept.
- div_divisor  in  32  rt value; sampled on accept.
- div_ready  out  1  controller can accept a request; high only in IDLE.
- div_done  out  1  one-cycle pulse; result commits at the end of this cycle.
- div_busy  out  1  high in BUSY or DONE.
- flush  in  1  exception/eret cancel of any in-flight divide.
- mthi_we  in  1  write HI.
- mtlo_we  in  1  write LO.
- mt_wdata  in  32  MTHI/MTLO data.
- hi_out  out  32  current HI value.
- lo_out  out  32  current LO value.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - state=IDLE, counter=0.
  - div_ready=1, div_done=0, div_busy=0.
  - hi_out=lo_out=HILO_RST_VAL.
  - Reset mid-divide aborts the operation with no HI/LO commit.
- States:
  - IDLE: div_valid & div_ready at edge T0 accepts the request. Latch |dividend|, |divisor| (absolute values only when div_signed), the sign flags and div_signed. Clear the partial remainder and counter. Go to BUSY.
  - BUSY: one restoring iteration per edge. Shift {rem,quo} left 1; trial-subtract the divisor from the 33-bit remainder. If non-negative, keep the difference and set quotient bit = 1. Counter increments 0..31. The edge at which counter==31 (T0+32) performs the last iteration and moves to DONE.
  - DONE (cycle between T0+32 and T0+33): div_done=1. At edge T0+33, commit HI=final remainder and LO=final quotient, then go to IDLE. div_ready is high from T0+33.
- Sign fixup (signed only):
  - Negate the quotient when the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero is not trapped. The algorithm yields quotient magnitude 0xFFFFFFFF and remainder magnitude |dividend|, followed by the normal sign fixup. The operation still takes the full 33 cycles.
- flush:
  - In BUSY or DONE, the next edge goes to IDLE with no commit, and div_done is forced to 0 in that cycle.
  - In IDLE, flush blocks acceptance in the same cycle.
  - flush has priority over div_valid.
- MTHI/MTLO:
  - mthi_we/mtlo_we write HI/LO at the next edge in any state and never stall.
  - If an MT write lands on the commit edge, the MT write wins for the targeted register; the other register takes the divide result.
- A div_valid held during BUSY/DONE is ignored; EX must hold it until div_ready.
- hi_out/lo_out are registered and change only at edges.
- Counter is 5 bits and wraps 31→0 on the DONE transition.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: hi_out/lo_out combinationally forward the value being written at the coming edge, with the same priority as above (MT write over divide commit over stored). This allows MFHI/MFLO in the same cycle as div_done or an MT write.
- Undefined: hi_out/lo_out are the pure register outputs; the pipeline must interlock one cycle after a write.

Test Plan:
- DIVU 100/7, accept at edge T0 -> div_done high only in cycle T0+32..T0+33; at T0+33 LO=14, HI=2, div_ready=1.
- DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5 after 33 cycles, no hang.
- Preload HI=0x11, LO=0x22; start DIVU 9/2; flush at T0+10 -> div_ready=1 at T0+11, no div_done, HI=0x11, LO=0x22.
- DIVU 9/2 with mthi_we=1, mt_wdata=0xABCD on edge T0+33 -> HI=0xABCD, LO=4. With HILO_BYPASS_EN, hi_out=0xABCD already in cycle T0+32.
- rst asserted at T0+20 of a divide -> state IDLE, HI=LO=HILO_RST_VAL, div_done never pulses; a new request is accepted the cycle after rst drops.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// HI/LO register pair with a 32-iteration restoring divider for DIV/DIVU.
// Handshakes with EX through div_valid/div_ready and a one-cycle div_done pulse.
// MTHI/MTLO writes take priority over the divide commit on the same edge.
// Optional macro HILO_BYPASS_EN: hi_out/lo_out forward the value written at the coming edge.
module hilo_div_ctrl #(
   parameter int unsigned          DATA_W       = 32,
   parameter logic [DATA_W-1:0]    HILO_RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              div_valid,
   input  logic              div_signed,
   input  logic [DATA_W-1:0] div_dividend,
   input  logic [DATA_W-1:0] div_divisor,
   output logic              div_ready,
   output logic              div_done,
   output logic              div_busy,
   input  logic              flush,
   input  logic              mthi_we,
   input  logic              mtlo_we,
   input  logic [DATA_W-1:0] mt_wdata,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q;
   logic [4:0]        cnt_q;
   logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
   logic              neg_quo_q, neg_rem_q;
   logic              ready_q, busy_q, done_q;
   logic [DATA_W-1:0] hi_q, lo_q, hi_d, lo_d;

   logic              a_neg, b_neg;
   logic [DATA_W-1:0] a_abs, b_abs;
   logic [DATA_W:0]   rem_sh, diff;
   logic [DATA_W-1:0] quo_sh, res_quo, res_rem;
   logic              commit;

   // Operand magnitudes, one restoring step, and the sign-fixed final result
   always_comb begin
      a_neg   = div_signed & div_dividend[DATA_W-1];
      b_neg   = div_signed & div_divisor[DATA_W-1];
      a_abs   = a_neg ? (~div_dividend + DATA_W'(1)) : div_dividend;
      b_abs   = b_neg ? (~div_divisor + DATA_W'(1)) : div_divisor;
      rem_sh  = {rem_q, quo_q[DATA_W-1]};
      diff    = rem_sh - {1'b0, dvs_q};
      quo_sh  = {quo_q[DATA_W-2:0], 1'b0};
      res_quo = neg_quo_q ? (~quo_q + DATA_W'(1)) : quo_q;
      res_rem = neg_rem_q ? (~rem_q + DATA_W'(1)) : rem_q;
   end

   // HI/LO next value: MT write beats divide commit beats hold
   always_comb begin
      commit = (state_q == StDone) & ~flush;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (commit) begin
         hi_d = res_rem;
         lo_d = res_quo;
      end
      if (mthi_we) hi_d = mt_wdata;
      if (mtlo_we) lo_d = mt_wdata;
   end

   // Divider FSM, datapath and HI/LO state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= HILO_RST_VAL;
         lo_q      <= HILO_RST_VAL;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         unique case (state_q)
            StIdle: begin
               if (div_valid && !flush) begin
                  rem_q     <= '0;
                  quo_q     <= a_abs;
                  dvs_q     <= b_abs;
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  cnt_q     <= '0;
                  state_q   <= StBusy;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            StBusy: begin
               if (flush) begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  if (!diff[DATA_W]) begin
                     rem_q <= diff[DATA_W-1:0];
                     quo_q <= quo_sh | DATA_W'(1);
                  end else begin
                     rem_q <= rem_sh[DATA_W-1:0];
                     quo_q <= quo_sh;
                  end
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDone: begin
               // Commit (or its cancellation by flush) is handled via hi_d/lo_d
               state_q <= StIdle;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign div_ready = ready_q;
   assign div_busy  = busy_q;
   assign div_done  = done_q & ~flush;

`ifdef HILO_BYPASS_EN
   assign hi_out = hi_d;
   assign lo_out = lo_d;
`else
   assign hi_out = hi_q;
   assign lo_out = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: directed cases plus random divides
// compared against an arithmetic reference of the HI/LO results.
module tb_hilo_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_valid, div_signed;
   logic [31:0] div_dividend, div_divisor;
   logic        div_ready, div_done, div_busy;
   logic        flush, mthi_we, mtlo_we;
   logic [31:0] mt_wdata, hi_out, lo_out;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_hi, exp_lo;

   hilo_div_ctrl #(
      .DATA_W       (32),
      .HILO_RST_VAL (32'h0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .div_valid    (div_valid),
      .div_signed   (div_signed),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_ready    (div_ready),
      .div_done     (div_done),
      .div_busy     (div_busy),
      .flush        (flush),
      .mthi_we      (mthi_we),
      .mtlo_we      (mtlo_we),
      .mt_wdata     (mt_wdata),
      .hi_out       (hi_out),
      .lo_out       (lo_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // MIPS DIV/DIVU semantics, with divide-by-zero defined as the unchecked algorithm result
   task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
      logic        na, nb;
      logic [31:0] ua, ub, uq, ur;
      na = s & a[31];
      nb = s & b[31];
      ua = na ? (~a + 32'd1) : a;
      ub = nb ? (~b + 32'd1) : b;
      if (ub == 32'd0) begin
         uq = 32'hFFFF_FFFF;
         ur = ua;
      end else begin
         uq = ua / ub;
         ur = ua % ub;
      end
      lo = (na ^ nb) ? (~uq + 32'd1) : uq;
      hi = na ? (~ur + 32'd1) : ur;
   endtask

   // Present a request for one edge (T0), then scramble operands to prove they were latched
   task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b);
      div_valid    = 1'b1;
      div_signed   = s;
      div_dividend = a;
      div_divisor  = b;
      step();
      div_valid    = 1'b0;
      div_signed   = 1'($urandom_range(0, 1));
      div_dividend = $urandom();
      div_divisor  = $urandom();
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (div_done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      int n;
      model(s, a, b, exp_hi, exp_lo);
      start(s, a, b);
      check("busy_after_accept", {31'd0, div_busy}, 32'd1);
      check("ready_after_accept", {31'd0, div_ready}, 32'd0);
      wait_done(n);
      check("done_latency", n, 32);
      step();
      check("done_cleared", {31'd0, div_done}, 32'd0);
      check("ready_after_commit", {31'd0, div_ready}, 32'd1);
      check("hi_result", hi_out, exp_hi);
      check("lo_result", lo_out, exp_lo);
   endtask

   initial begin
      int          n, dones;
      logic        s;
      logic [31:0] a, b;

      rst = 1'b1; div_valid = 1'b0; div_signed = 1'b0; div_dividend = '0; div_divisor = '0;
      flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_wdata = '0;
      step();
      step();
      check("rst_ready", {31'd0, div_ready}, 32'd1);
      check("rst_done", {31'd0, div_done}, 32'd0);
      check("rst_busy", {31'd0, div_busy}, 32'd0);
      check("rst_hi", hi_out, 32'h0);
      check("rst_lo", lo_out, 32'h0);
      rst = 1'b0;
      step();

      // Directed divides
      run_div(1'b0, 32'd100, 32'd7);
      check("divu_100_7_lo", lo_out, 32'd14);
      check("divu_100_7_hi", hi_out, 32'd2);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
      check("div_m7_2_lo", lo_out, 32'hFFFF_FFFD);
      check("div_m7_2_hi", hi_out, 32'hFFFF_FFFF);
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_min_m1_lo", lo_out, 32'h8000_0000);
      check("div_min_m1_hi", hi_out, 32'h0);
      run_div(1'b0, 32'd5, 32'd0);
      check("divu_5_0_lo", lo_out, 32'hFFFF_FFFF);
      check("divu_5_0_hi", hi_out, 32'd5);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd0);

      // MT preload then flush mid-divide
      mthi_we = 1'b1; mt_wdata = 32'h11;
      step();
      mthi_we = 1'b0; mtlo_we = 1'b1; mt_wdata = 32'h22;
      step();
      mtlo_we = 1'b0;
      check("mthi_preload", hi_out, 32'h11);
      check("mtlo_preload", lo_out, 32'h22);
      start(1'b0, 32'd9, 32'd2);
      dones = 0;
      for (int i = 1; i < 10; i++) begin
         step();
         if (div_done === 1'b1) dones++;
      end
      step();
      flush = 1'b1;
      #1;
      if (div_done === 1'b1) dones++;
      step();
      flush = 1'b0;
      check("flush_busy_ready", {31'd0, div_ready}, 32'd1);
      check("flush_busy_busy", {31'd0, div_busy}, 32'd0);
      for (int i = 0; i < 30; i++) begin
         step();
         if (div_done === 1'b1) dones++;
      end
      check("flush_no_done", dones, 0);
      check("flush_hi_kept", hi_out, 32'h11);
      check("flush_lo_kept", lo_out, 32'h22);

      // Flush in IDLE blocks acceptance; request goes through once flush drops
      div_valid = 1'b1; div_signed = 1'b0; div_dividend = 32'd77; div_divisor = 32'd10;
      flush = 1'b1;
      step();
      check("flush_idle_busy", {31'd0, div_busy}, 32'd0);
      check("flush_idle_ready", {31'd0, div_ready}, 32'd1);
      flush = 1'b0;
      step();
      div_valid = 1'b0;
      check("post_flush_accept", {31'd0, div_busy}, 32'd1);
      wait_done(n);
      check("post_flush_latency", n, 32);
      step();
      check("post_flush_lo", lo_out, 32'd7);
      check("post_flush_hi", hi_out, 32'd7);
      exp_hi = 32'd7; exp_lo = 32'd7;

      // Flush during DONE suppresses the pulse and the commit
      start(1'b0, 32'd1000, 32'd3);
      wait_done(n);
      check("done_flush_latency", n, 32);
      flush = 1'b1;
      #1;
      check("done_forced_low", {31'd0, div_done}, 32'd0);
      step();
      flush = 1'b0;
      check("done_flush_ready", {31'd0, div_ready}, 32'd1);
      check("done_flush_hi", hi_out, exp_hi);
      check("done_flush_lo", lo_out, exp_lo);

      // MTHI on the commit edge wins for HI; LO still takes the quotient
      start(1'b0, 32'd9, 32'd2);
      wait_done(n);
      check("mt_commit_latency", n, 32);
      mthi_we = 1'b1; mt_wdata = 32'hABCD;
      #1;
`ifdef HILO_BYPASS_EN
      check("bypass_hi", hi_out, 32'hABCD);
      check("bypass_lo", lo_out, 32'd4);
`else
      check("nobypass_hi", hi_out, exp_hi);
      check("nobypass_lo", lo_out, exp_lo);
`endif
      step();
      mthi_we = 1'b0;
      check("mt_commit_hi", hi_out, 32'hABCD);
      check("mt_commit_lo", lo_out, 32'd4);

      // Reset mid-divide aborts without commit; next request accepted right after
      start(1'b0, 32'd9, 32'd2);
      dones = 0;
      for (int i = 1; i < 20; i++) begin
         step();
         if (div_done === 1'b1) dones++;
      end
      rst = 1'b1;
      step();
      check("midrst_ready", {31'd0, div_ready}, 32'd1);
      check("midrst_busy", {31'd0, div_busy}, 32'd0);
      check("midrst_hi", hi_out, 32'h0);
      check("midrst_lo", lo_out, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (div_done === 1'b1) dones++;
         if (i < 19) step();
      end
      check("midrst_no_done", dones, 0);
      run_div(1'b0, 32'd100, 32'd7);

      // Random divides against the reference
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom();
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(1, 15));
            1: b = $urandom();
            2: b = 32'd0;
            default: b = s ? 32'hFFFF_FFFF : 32'($urandom_range(1, 3));
         endcase
         run_div(s, a, b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
